// File: rtl/mem_arbiter.sv
// Purpose : shares one physical memory port between the icache (read-only) and the dcache (read/write).
// Latency : request -> pmem strobe 1 cycle; resp is combinational with pmem_resp; one IDLE cycle after each completion.
// Backpr. : requests are held until their resp; stall_i/stall_d stay high until the matching resp pulse.
// Optional: define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both caches request (default: dcache priority).
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    // icache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // dcache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // physical memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    // pipeline stalls
    output logic              stall_i,
    output logic              stall_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    // last_grant encoding: 0 = icache, 1 = dcache
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t              state_q, state_d;
    logic                pmem_read_q, pmem_read_d;
    logic                pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0]   pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0]   pmem_wdata_q, pmem_wdata_d;
    logic                last_grant_q, last_grant_d;

    logic                i_req;
    logic                d_req;
    logic                grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Winner selection while IDLE; only meaningful when at least one request is pending.
    always_comb begin
        grant_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Contended: the cache not served last wins; a sole requester always wins.
        grant_d = d_req & (~i_req | (last_grant_q == GRANT_I));
`else
        // Fixed priority: dcache wins whenever it requests; last_grant is bookkeeping only.
        grant_d = d_req;
`endif
    end

    // Next-state, request latching and completion handling.
    always_comb begin
        state_d        = state_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        last_grant_d   = last_grant_q;

        unique case (state_q)
            IDLE: begin
                // Stray pmem_resp here is ignored: nothing is outstanding.
                if (grant_d) begin
                    state_d        = SERVE_D;
                    pmem_address_d = d_address;
                    // Read+write together is treated as a write.
                    if (d_write) begin
                        pmem_write_d = 1'b1;
                        pmem_read_d  = 1'b0;
                        pmem_wdata_d = d_wdata;
                    end else begin
                        pmem_write_d = 1'b0;
                        pmem_read_d  = 1'b1;
                    end
                end else if (i_req) begin
                    state_d        = SERVE_I;
                    pmem_address_d = i_address;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                end
            end
            SERVE_I: begin
                // Address/data stay latched until completion regardless of requester inputs.
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    last_grant_d = GRANT_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    last_grant_d = GRANT_D;
                end
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    // State and latched memory-request registers; async reset abandons any outstanding transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            last_grant_q   <= GRANT_I;
        end else begin
            state_q        <= state_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            last_grant_q   <= last_grant_d;
        end
    end

    // Memory port driven straight from the latched request.
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

    // Completion is routed combinationally to whichever cache owns the port.
    assign i_resp  = (state_q == SERVE_I) & pmem_resp;
    assign d_resp  = (state_q == SERVE_D) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // A requester is stalled from request until the cycle its resp pulses.
    assign stall_i = i_req & ~i_resp;
    assign stall_d = d_req & ~d_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter; transaction-level model of grant order and data routing.
// Latency : expects strobe 1 cycle after a request in IDLE and one IDLE cycle after every completion.
// Backpr. : bench plays both caches (hold request until resp) and the memory (random response latency).
`define CHK(TAG, OBS, EXP) chk(TAG, 256'(OBS), 256'(EXP))

module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              stall_i;
    logic              stall_d;

    int errors = 0;
    int checks = 0;
    bit last_d = 1'b0;   // model of last_grant: 0 = icache, 1 = dcache

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .stall_i(stall_i), .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        #3;
        if (rst_n === 1'b1) begin
            checks++;
            if (stall_i !== (i_read & ~i_resp)) begin
                errors++;
                $error("FAIL mon_stall_i observed=%0b", stall_i);
            end
            checks++;
            if (stall_d !== ((d_read | d_write) & ~d_resp)) begin
                errors++;
                $error("FAIL mon_stall_d observed=%0b", stall_d);
            end
            checks++;
            if ((pmem_read & pmem_write) !== 1'b0) begin
                errors++;
                $error("FAIL mon_both_strobes");
            end
            checks++;
            if ((i_resp & d_resp) !== 1'b0) begin
                errors++;
                $error("FAIL mon_both_resps");
            end
            checks++;
            if (pmem_resp === 1'b0 && (i_resp | d_resp) !== 1'b0) begin
                errors++;
                $error("FAIL mon_resp_without_pmem_resp");
            end
        end else if (rst_n === 1'b0) begin
            checks++;
            if ((pmem_read | pmem_write | i_resp | d_resp) !== 1'b0) begin
                errors++;
                $error("FAIL mon_reset_outputs");
            end
        end
    end

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // Grant rule when in IDLE with the given pending requests.
    function automatic bit pick_d(input bit ireq, input bit dreq);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return dreq && (!ireq || !last_d);
`else
        return dreq;
`endif
    endfunction

    // One complete transaction for the expected winner, from strobe to the trailing IDLE cycle.
    task automatic serve_one(input bit who_d, input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                             input bit exp_wr, input int lat, input logic [255:0] rdata, input bit scramble);
        int waited;
        bit seen;
        waited = 0;
        seen   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!seen) begin
                @(negedge clk); #1;
                if (pmem_read || pmem_write) seen = 1'b1;
                else waited++;
            end
        end
        `CHK("grant_latency", waited, 0);
        `CHK("strobe_write", pmem_write, exp_wr);
        `CHK("strobe_read", pmem_read, !exp_wr);
        `CHK("pmem_address", pmem_address, exp_addr);
        if (exp_wr) `CHK("pmem_wdata", pmem_wdata, exp_wdata);
        for (int j = 0; j < lat; j++) begin
            if (scramble && j == 0) begin
                if (who_d) begin
                    d_wdata   = '0;
                    d_address = $urandom();
                end else begin
                    i_address = $urandom();
                end
            end
            @(negedge clk); #1;
            `CHK("hold_write", pmem_write, exp_wr);
            `CHK("hold_read", pmem_read, !exp_wr);
            `CHK("hold_address", pmem_address, exp_addr);
            if (exp_wr) `CHK("hold_wdata", pmem_wdata, exp_wdata);
            `CHK("wait_i_resp", i_resp, 0);
            `CHK("wait_d_resp", d_resp, 0);
            `CHK("wait_stall_i", stall_i, i_read);
            `CHK("wait_stall_d", stall_d, d_read | d_write);
        end
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        #1;
        `CHK("resp_i", i_resp, !who_d);
        `CHK("resp_d", d_resp, who_d);
        if (who_d) begin
            `CHK("d_rdata", d_rdata, rdata);
            `CHK("resp_stall_d", stall_d, 0);
            `CHK("resp_stall_i", stall_i, i_read);
        end else begin
            `CHK("i_rdata", i_rdata, rdata);
            `CHK("resp_stall_i", stall_i, 0);
            `CHK("resp_stall_d", stall_d, d_read | d_write);
        end
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = rnd_line();
        if (who_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        last_d = who_d;
        #1;
        `CHK("idle_read", pmem_read, 0);
        `CHK("idle_write", pmem_write, 0);
        `CHK("idle_i_resp", i_resp, 0);
        `CHK("idle_d_resp", d_resp, 0);
    endtask

    // Raise the chosen requests together in IDLE and serve them in model order.
    task automatic run_scenario(input bit ir, input bit dr, input bit dw,
                                input logic [31:0] ia, input logic [31:0] da, input logic [255:0] wd,
                                input int lat1, input int lat2, input bit scramble);
        bit first_d;
        @(negedge clk);
        i_read    = ir;
        i_address = ia;
        d_read    = dr;
        d_write   = dw;
        d_address = da;
        d_wdata   = wd;
        if (!ir && !(dr || dw)) begin
            pmem_resp = 1'b1;
            #1;
            `CHK("stray_i_resp", i_resp, 0);
            `CHK("stray_d_resp", d_resp, 0);
            @(negedge clk);
            pmem_resp = 1'b0;
            #1;
            `CHK("stray_read", pmem_read, 0);
            `CHK("stray_write", pmem_write, 0);
            return;
        end
        first_d = pick_d(ir, dr || dw);
        if (first_d) serve_one(1'b1, da, wd, dw, lat1, rnd_line(), scramble);
        else         serve_one(1'b0, ia, '0, 1'b0, lat1, rnd_line(), scramble);
        if (first_d && ir)             serve_one(1'b0, ia, '0, 1'b0, lat2, rnd_line(), 1'b0);
        else if (!first_d && (dr || dw)) serve_one(1'b1, da, wd, dw, lat2, rnd_line(), 1'b0);
    endtask

    initial begin
        logic [255:0] a5_line;
        logic [255:0] w1234;
        logic [255:0] wr;
        a5_line = {32{8'hA5}};
        w1234   = {8{32'h1234_5678}};

        rst_n      = 1'b0;
        i_read     = 1'b1;
        i_address  = 32'h0000_0080;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            `CHK("rst_read", pmem_read, 0);
            `CHK("rst_write", pmem_write, 0);
            `CHK("rst_address", pmem_address, 0);
            `CHK("rst_wdata", pmem_wdata, 0);
            `CHK("rst_i_resp", i_resp, 0);
            `CHK("rst_stall_i", stall_i, 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        serve_one(1'b0, 32'h0000_0080, '0, 1'b0, 1, rnd_line(), 1'b0);

        run_scenario(1'b1, 1'b0, 1'b0, 32'h0000_0040, '0, '0, 3, 0, 1'b0);
        @(negedge clk);
        i_read = 1'b1; i_address = 32'h0000_0040;
        serve_one(1'b0, 32'h0000_0040, '0, 1'b0, 3, a5_line, 1'b0);

        run_scenario(1'b0, 1'b0, 1'b1, '0, 32'h0000_1000, w1234, 4, 0, 1'b1);

        run_scenario(1'b1, 1'b1, 1'b0, 32'h0000_2040, 32'h0000_3000, '0, 2, 2, 1'b0);

        @(negedge clk);
        d_write = 1'b1; d_address = 32'h0000_4000; d_wdata = rnd_line();
        @(negedge clk); #1;
        `CHK("rstmid_write_before", pmem_write, 1);
        rst_n = 1'b0;
        #1;
        `CHK("rstmid_write", pmem_write, 0);
        `CHK("rstmid_read", pmem_read, 0);
        `CHK("rstmid_address", pmem_address, 0);
        `CHK("rstmid_d_resp", d_resp, 0);
        @(negedge clk);
        rst_n = 1'b1; d_write = 1'b0; last_d = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        `CHK("late_d_resp", d_resp, 0);
        `CHK("late_i_resp", i_resp, 0);
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        `CHK("late_write", pmem_write, 0);
        run_scenario(1'b1, 1'b0, 1'b1, 32'h0000_5000, 32'h0000_6000, w1234, 1, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            wr = rnd_line();
            run_scenario(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom(), $urandom(), wr,
                         int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                         1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        @(negedge clk);
        if (errors == 0) $display("PASS: %0d checks", checks);
        else $display("FAIL: errors=%0d of %0d checks", errors, checks);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between the instruction cache (read-only) and the data cache (read/write).
- Latches the winning request, drives it to physical memory, and routes the response back to the winner.
- Generates per-requester pipeline stall signals from the arbitration state.
- Sits between the L1 caches and physical memory at the memory side of the pipeline.

Parameters:
- ADDR_W, 32, byte address width of all address ports.
- LINE_W, 256, cache line width in bits for all data ports.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  icache line read request; held until i_resp.
- i_address  in  ADDR_W  icache request address.
- i_rdata  out  LINE_W  icache read data, valid when i_resp=1.
- i_resp  out  1  one-cycle icache completion pulse.
- d_read  in  1  dcache line read request; held until d_resp.
- d_write  in  1  dcache line write request; held until d_resp.
- d_address  in  ADDR_W  dcache request address.
- d_wdata  in  LINE_W  dcache write data.
- d_rdata  out  LINE_W  dcache read data, valid when d_resp=1.
- d_resp  out  1  one-cycle dcache completion pulse.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_W  registered physical address.
- pmem_wdata  out  LINE_W  registered write data.
- pmem_rdata  in  LINE_W  physical memory read data.
- pmem_resp  in  1  physical memory completion pulse.
- stall_i  out  1  fetch-stage stall.
- stall_d  out  1  memory-stage stall.

Behaviour:
- Reset values:
  - state=IDLE.
  - pmem_read, pmem_write, pmem_address, pmem_wdata all 0.
  - i_resp, d_resp = 0.
  - last_grant = I.
- States:
  - IDLE:
    - If no request is pending, remain in IDLE.
    - Otherwise select a winner per the arbitration policy.
    - On the next edge, register the winner's address (and d_wdata for a write) into pmem_address/pmem_wdata, set pmem_read or pmem_write, and go to SERVE_I or SERVE_D.
  - SERVE_I:
    - pmem_read=1. Wait for pmem_resp.
    - On pmem_resp, i_resp=1 in the same cycle (combinational) and i_rdata=pmem_rdata.
    - Next edge: clear strobes, go to IDLE, set last_grant=I.
  - SERVE_D:
    - Same as SERVE_I but uses d_resp/d_rdata; pmem_write=1 for writes, pmem_read=1 for reads.
    - On completion, last_grant=D.
- Arbitration policy (default): fixed priority; the dcache wins whenever d_read|d_write is asserted in IDLE.
- Latency: minimum request-to-strobe latency is 1 cycle; minimum request-to-resp latency is 1 cycle plus memory latency.
- Mandatory IDLE cycle: at least one IDLE cycle follows every completion. A requester drops its request in the cycle after resp, so it is never served twice.
- Input stability: pmem_address and pmem_wdata hold constant for the whole transaction regardless of requester input changes.
- d_read and d_write both high: treated as a write.
- i_rdata/d_rdata: drive pmem_rdata unconditionally; only meaningful when the matching resp is 1.
- pmem_resp in IDLE: ignored, no resp generated.
- Stall outputs (combinational):
  - stall_i = i_read & ~i_resp.
  - stall_d = (d_read|d_write) & ~d_resp.
  - A requester waiting for grant is stalled; stall drops in the cycle its resp pulses.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). The outstanding memory transaction is abandoned and any subsequent pmem_resp arriving in IDLE is ignored.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both caches request in IDLE, grant the requester that is not last_grant. A sole requester is always granted. This guarantees neither cache waits more than one foreign transaction.
- Undefined: fixed dcache priority. last_grant is still maintained but has no effect on arbitration.

Test Plan:
- Reset with i_read=1 held -> all pmem strobes 0 and i_resp=0 while rst_n=0. After release: pmem_read=1, pmem_address=i_address one cycle later, stall_i=1 throughout.
- Icache read of 0x0000_0040, memory resp after 3 cycles with rdata=0xA5..A5 -> i_resp pulses exactly 1 cycle, i_rdata=0xA5..A5, stall_i falls that cycle, next cycle state IDLE.
- Dcache write to 0x0000_1000 with d_wdata=0x1234..; d_wdata changed to 0 mid-transaction -> pmem_write=1 and pmem_wdata stays 0x1234.. until pmem_resp; d_resp pulses once.
- i_read and d_read asserted together, held until resp, with MEM_ARB_ROUND_ROBIN_EN undefined -> dcache served first, icache second. Each completion is followed by one IDLE cycle, and exactly two pmem transactions occur.
- With MEM_ARB_ROUND_ROBIN_EN defined, back-to-back dcache requests and a continuous i_read -> grants alternate D, I, D, I; the icache waits for at most one dcache transaction.
- rst_n pulsed low during SERVE_D, and pmem_resp later arrives in IDLE -> no d_resp generated, pmem_write=0, and the next request is arbitrated normally.
